burst_traffic_checker: RTL and testbench

- Synthesizable, self-checking burst traffic source and scoreboard for the I2C transceiver top level.
- Software configures word size, burst length and seed through a small register port, then issues `start`. The block pulses `startTx` and supplies pseudo-random `txdata` on each `readydata` request.
- It queues the expected words and compares each `rxValid` beat against the queue head, with the comparison masked to the configured size.
- It reports pass and error counts, sticky fault flags, and a `done` pulse.

---
 rtl/burst_traffic_checker.sv | 169 ++++++++++++++++
 tb/tb_burst_traffic_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_traffic_checker.sv
// Burst traffic source and in-order scoreboard for an I2C transceiver loopback.
// Emits LFSR words on request, checks returned words against a FIFO of expectations.
module burst_traffic_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [3:0]        addin,
    input  logic [7:0]        data,
    input  logic              start,
    output logic              startTx,
    input  logic              readydata,
    output logic [DATA_W-1:0] txdata,
    input  logic              rxValid,
    input  logic [DATA_W-1:0] rxOut,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [3:0]        flags
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [5:0]        size_q, size_d;
    logic [7:0]        burst_q, seed_q;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [DATA_W-1:0] txdata_q, mask, tx_word;
    logic              start_tx_q, done_q;
    logic [CNT_W-1:0]  pass_q, err_q;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [7:0]        tx_cnt_q, rx_cnt_q;
    logic [TW-1:0]     tmo_q;
    logic              in_run, fifo_full, fifo_empty, acc_tx, acc_rx;
    logic              push, pop, ovf, unexp, mism, err_ev, all_done, tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign mask[gi] = (size_q > 6'(gi));
    end

    assign size_d  = (data == 8'd0 || data > 8'(DATA_W)) ? 6'(DATA_W) : data[5:0];
    assign lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    assign tx_word = lfsr_q[DATA_W-1:0] & mask;

    assign in_run     = (state_q == S_RUN);
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign acc_tx     = in_run && readydata && (tx_cnt_q < burst_q);
    assign acc_rx     = in_run && rxValid && (rx_cnt_q < burst_q);
    assign pop        = acc_rx && !fifo_empty;
    assign unexp      = acc_rx && fifo_empty;
    assign mism       = pop && ((rxOut & mask) != fifo_mem[rd_ptr_q]);
    // A same-cycle pop frees the slot, so a push onto a full FIFO is still legal then.
    assign push       = acc_tx && (!fifo_full || pop);
    assign ovf        = acc_tx && fifo_full && !pop;
    assign err_ev     = ovf || unexp || mism;
    assign all_done   = (tx_cnt_q == burst_q) && (rx_cnt_q == burst_q);
    assign tmo_hit    = in_run && !all_done && (tmo_q == TW'(TIMEOUT));
    assign flags_d    = flags_q | {tmo_hit, ovf, unexp, mism};

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= tx_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            size_q     <= 6'(DATA_W);
            burst_q    <= 8'd1;
            seed_q     <= 8'hA5;
            lfsr_q     <= '0;
            txdata_q   <= '0;
            start_tx_q <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= '0;
            err_q      <= '0;
            flags_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tmo_q      <= '0;
        end else begin
            start_tx_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (write) begin
                        case (addin)
                            4'd1:    size_q  <= size_d;
                            4'd2:    burst_q <= data;
                            4'd3:    seed_q  <= data;
                            default: ;
                        endcase
                    end
                    if (start) begin
                        if (burst_q == 8'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_LAUNCH;
                            start_tx_q <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    pass_q   <= '0;
                    err_q    <= '0;
                    flags_q  <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    tx_cnt_q <= '0;
                    rx_cnt_q <= '0;
                    tmo_q    <= '0;
                    lfsr_q   <= {seed_q, ~seed_q, seed_q, ~seed_q};
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    if (acc_tx) begin
                        txdata_q <= tx_word;
                        lfsr_q   <= lfsr_d;
                        tx_cnt_q <= tx_cnt_q + 8'd1;
                    end
                    if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                    count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
                    // An overflowed word can never be checked, so it is retired as a failed beat.
                    if (pop || ovf) rx_cnt_q <= rx_cnt_q + 8'd1;
                    if (pop && !mism) pass_q <= sat_inc(pass_q);
                    if (err_ev) err_q <= sat_inc(err_q);
                    flags_q <= flags_d;
                    if (rxValid) tmo_q <= '0;
                    else if (rx_cnt_q < burst_q) tmo_q <= tmo_q + TW'(1);
                    if (all_done || tmo_hit) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: state_q <= S_IDLE;
            endcase
        end
    end

    assign startTx    = start_tx_q;
    assign txdata     = txdata_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign pass_count = pass_q;
    assign err_count  = err_q;
    assign flags      = flags_q;
endmodule

// File: tb/tb_burst_traffic_checker.sv
// Randomised directed bench for burst_traffic_checker; expected words come from a
// reference LFSR sequence and expected counts from the burst's scripted faults.
`timescale 1ns/1ps
module tb_burst_traffic_checker;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 100;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write = 1'b0;
    logic [3:0]    addin = '0;
    logic [7:0]    data = '0;
    logic          start = 1'b0;
    logic          startTx;
    logic          readydata = 1'b0;
    logic [DW-1:0] txdata;
    logic          rxValid = 1'b0;
    logic [DW-1:0] rxOut = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] err_count;
    logic [3:0]    flags;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mw [256];

    burst_traffic_checker #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .write(write), .addin(addin), .data(data),
        .start(start), .startTx(startTx), .readydata(readydata), .txdata(txdata),
        .rxValid(rxValid), .rxOut(rxOut), .busy(busy), .done(done),
        .pass_count(pass_count), .err_count(err_count), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] size_mask(input int sz);
        int eff;
        eff = (sz == 0 || sz > DW) ? DW : sz;
        return (eff >= 32) ? 32'hFFFF_FFFF : ((32'h1 << eff) - 32'h1);
    endfunction

    // Reference word stream: Galois LFSR x^32+x^22+x^2+x+1, seeded {s,~s,s,~s}.
    task automatic build_model(input logic [7:0] seed, input int sz, input int n);
        logic [31:0] s;
        s = {seed, ~seed, seed, ~seed};
        for (int i = 0; i < n; i++) begin
            mw[i] = s & size_mask(sz);
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] v);
        addin = a;
        data  = v;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("launch_startTx", 32'(startTx), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        tick();
        chk("run_startTx_low", 32'(startTx), 32'd0);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    // mode 0: exact loopback, 1: upper bits forced high, 2: bit0 flipped on beat `corrupt`
    task automatic run_burst(input int sz, input int burst, input logic [7:0] seed,
                             input int mode, input int corrupt);
        int          dq_due[$];
        logic [31:0] dq_w[$];
        logic [31:0] w;
        int acc, rxi, extra_st, due;
        bit rd_last, got;
        write_reg(4'd1, 8'(sz));
        write_reg(4'd2, 8'(burst));
        write_reg(4'd3, seed);
        build_model(seed, sz, burst);
        launch();
        acc = 0; rxi = 0; extra_st = 0; rd_last = 1'b0; got = 1'b0;
        for (int cyc = 0; cyc < 400 && !got; cyc++) begin
            if (rd_last && acc < burst) begin
                chk("txdata", txdata, mw[acc]);
                chk("tx_unmasked_zero", txdata & ~size_mask(sz), 32'd0);
                dq_due.push_back(cyc + 3);
                dq_w.push_back(txdata);
                acc++;
            end
            if (startTx) extra_st++;
            if (done) got = 1'b1;
            rxValid = 1'b0;
            if (dq_due.size() > 0 && dq_due[0] <= cyc) begin
                w = dq_w.pop_front();
                due = dq_due.pop_front();
                rxValid = 1'b1;
                case (mode)
                    1:       rxOut = w | 32'hFFFF_FFF0;
                    2:       rxOut = (rxi == corrupt) ? (w ^ 32'h1) : w;
                    default: rxOut = w;
                endcase
                rxi++;
            end
            readydata = ($urandom_range(0, 2) != 0);
            rd_last = readydata;
            if (!got) tick();
        end
        readydata = 1'b0;
        rxValid = 1'b0;
        chk("burst_done", 32'(got), 32'd1);
        chk("no_extra_startTx", 32'(extra_st), 32'd0);
        chk("pass_count", 32'(pass_count), (mode == 2) ? 32'(burst - 1) : 32'(burst));
        chk("err_count", 32'(err_count), (mode == 2) ? 32'd1 : 32'd0);
        chk("flags", 32'(flags), (mode == 2) ? 32'd1 : 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        $display("burst size=%0d len=%0d seed=%02h mode=%0d pass=%0d err=%0d flags=%b",
                 sz, burst, seed, mode, pass_count, err_count, flags);
    endtask

    initial begin
        int n;
        logic [7:0] sd;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_startTx", 32'(startTx), 32'd0);
        chk("rst_txdata", txdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        reset = 1'b0;
        tick();

        run_burst(8, 2, 8'hA5, 0, 0);
        run_burst(4, int'($urandom_range(3, 6)), 8'($urandom), 1, 0);
        run_burst(int'($urandom_range(8, 32)), 4, 8'($urandom), 2, 2);
        for (int k = 0; k < 3; k++)
            run_burst(int'($urandom_range(0, 40)), int'($urandom_range(1, 12)), 8'($urandom), 0, 0);

        // Overflow: 10 words into an 8-deep FIFO with nothing returning.
        sd = 8'($urandom);
        write_reg(4'd1, 8'd32);
        write_reg(4'd2, 8'd10);
        write_reg(4'd3, sd);
        build_model(sd, 32, 10);
        launch();
        readydata = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ovf_txdata", txdata, mw[i]);
        end
        readydata = 1'b0;
        wait_done(3 * TMO, n);
        chk("ovf_err", 32'(err_count), 32'd2);
        chk("ovf_pass", 32'(pass_count), 32'd0);
        chk("ovf_flags", 32'(flags), 32'hC);
        $display("overflow burst err=%0d flags=%b", err_count, flags);
        tick();

        // Stray rxValid after reset with no burst running.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rxValid = 1'b1;
        rxOut = $urandom;
        tick();
        rxValid = 1'b0;
        tick();
        chk("stray_rx_err", 32'(err_count), 32'd0);
        chk("stray_rx_flags", 32'(flags), 32'd0);
        chk("stray_rx_busy", 32'(busy), 32'd0);

        // Timeout: nothing requested or returned.
        write_reg(4'd2, 8'd3);
        launch();
        wait_done(3 * TMO, n);
        chk("timeout_latency", 32'(n + 1), 32'(TMO + 2));
        chk("timeout_flags", 32'(flags), 32'h8);
        chk("timeout_err", 32'(err_count), 32'd0);
        $display("timeout burst latency=%0d flags=%b", n + 1, flags);
        tick();

        // Zero-length burst.
        write_reg(4'd2, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_burst_done", 32'(done), 32'd1);
        chk("zero_burst_startTx", 32'(startTx), 32'd0);
        tick();
        chk("zero_burst_done_end", 32'(done), 32'd0);
        chk("zero_burst_flags_kept", 32'(flags), 32'h8);
        $display("zero-length burst done");

        // Size write during RUN must be ignored, then reset mid-burst.
        write_reg(4'd1, 8'd8);
        write_reg(4'd2, 8'd5);
        write_reg(4'd3, 8'hA5);
        build_model(8'hA5, 8, 5);
        launch();
        write_reg(4'd1, 8'd4);
        readydata = 1'b1;
        tick();
        readydata = 1'b0;
        chk("cfg_lock_txdata", txdata, mw[0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_startTx", 32'(startTx), 32'd0);
        chk("midrst_txdata", txdata, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_counts", 32'({pass_count, err_count}), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        tick();
        chk("midrst_no_done", 32'(done), 32'd0);
        $display("mid-burst reset handled");

        // Reset register values: size=DATA_W, burst=1, seed=A5.
        build_model(8'hA5, 32, 1);
        launch();
        readydata = 1'b1;
        tick();
        readydata = 1'b0;
        chk("default_txdata", txdata, mw[0]);
        rxValid = 1'b1;
        rxOut = mw[0];
        tick();
        rxValid = 1'b0;
        wait_done(20, n);
        chk("default_pass", 32'(pass_count), 32'd1);
        chk("default_err", 32'(err_count), 32'd0);
        chk("default_flags", 32'(flags), 32'd0);
        $display("default-config burst pass=%0d", pass_count);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
